// File: rtl/instr_sequencer_pkg.sv
// rtl/instr_sequencer_pkg.sv - ALU op codes, opcode field patterns and Q-phase encoding
package instr_sequencer_pkg;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_AND    = 4'd2;
  localparam logic [3:0] ALU_OR     = 4'd3;
  localparam logic [3:0] ALU_XOR    = 4'd4;
  localparam logic [3:0] ALU_COM    = 4'd5;
  localparam logic [3:0] ALU_INC    = 4'd6;
  localparam logic [3:0] ALU_DEC    = 4'd7;
  localparam logic [3:0] ALU_RLF    = 4'd8;
  localparam logic [3:0] ALU_RRF    = 4'd9;
  localparam logic [3:0] ALU_SWAPF  = 4'd10;
  localparam logic [3:0] ALU_PASSLF = 4'd11;
  localparam logic [3:0] ALU_PASSW  = 4'd12;
  localparam logic [3:0] ALU_ZERO   = 4'd13;
  localparam logic [3:0] ALU_BC     = 4'd14;
  localparam logic [3:0] ALU_BS     = 4'd15;

  typedef enum logic [1:0] {
    Q1 = 2'd0,
    Q2 = 2'd1,
    Q3 = 2'd2,
    Q4 = 2'd3
  } q_phase_e;

  // ir[13:12] instruction groups
  localparam logic [1:0] GRP_BYTE = 2'b00;
  localparam logic [1:0] GRP_BIT  = 2'b01;
  localparam logic [1:0] GRP_CTRL = 2'b10;
  localparam logic [1:0] GRP_LIT  = 2'b11;

  // ir[11:8] byte-oriented opcodes
  localparam logic [3:0] BOP_MISC   = 4'd0;
  localparam logic [3:0] BOP_CLR    = 4'd1;
  localparam logic [3:0] BOP_SUBWF  = 4'd2;
  localparam logic [3:0] BOP_DECF   = 4'd3;
  localparam logic [3:0] BOP_IORWF  = 4'd4;
  localparam logic [3:0] BOP_ANDWF  = 4'd5;
  localparam logic [3:0] BOP_XORWF  = 4'd6;
  localparam logic [3:0] BOP_ADDWF  = 4'd7;
  localparam logic [3:0] BOP_MOVF   = 4'd8;
  localparam logic [3:0] BOP_COMF   = 4'd9;
  localparam logic [3:0] BOP_INCF   = 4'd10;
  localparam logic [3:0] BOP_DECFSZ = 4'd11;
  localparam logic [3:0] BOP_RRF    = 4'd12;
  localparam logic [3:0] BOP_RLF    = 4'd13;
  localparam logic [3:0] BOP_SWAPF  = 4'd14;
  localparam logic [3:0] BOP_INCFSZ = 4'd15;

  // ir[11:10] bit-oriented opcodes
  localparam logic [1:0] BIT_BCF   = 2'd0;
  localparam logic [1:0] BIT_BSF   = 2'd1;
  localparam logic [1:0] BIT_BTFSC = 2'd2;
  localparam logic [1:0] BIT_BTFSS = 2'd3;

  localparam logic [13:0] INSTR_NOP    = 14'h0000;
  localparam logic [13:0] INSTR_RETURN = 14'h0008;

endpackage

// File: rtl/instr_sequencer_decode.sv
// rtl/instr_sequencer_decode.sv - combinational decode of the 14-bit opcode into ALU and PC controls
module instr_decode
  import instr_sequencer_pkg::*;
(
  input  logic [13:0] i_ir,
  output logic [3:0]  o_alu_op,
  output logic        o_alu_d,
  output logic        o_d_wr,
  output logic        o_status_wr,
  output logic        o_lit_sel,
  output logic        o_stack_push,
  output logic        o_load_lit,
  output logic        o_load_stack,
  output logic        o_skip_bit,
  output logic        o_skip_zero
);

  always_comb begin
    o_alu_op     = ALU_ADD;
    o_alu_d      = 1'b0;
    o_d_wr       = 1'b0;
    o_status_wr  = 1'b0;
    o_lit_sel    = 1'b0;
    o_stack_push = 1'b0;
    o_load_lit   = 1'b0;
    o_load_stack = 1'b0;
    o_skip_bit   = 1'b0;
    o_skip_zero  = 1'b0;
    case (i_ir[13:12])
      GRP_BYTE: begin
        if (i_ir[11:8] == BOP_MISC) begin
          // d=1 is movwf; d=0 holds nop/return/retfie/sleep/clrwdt, only return acts
          if (i_ir[7]) begin
            o_alu_op = ALU_PASSW;
            o_alu_d  = 1'b1;
            o_d_wr   = 1'b1;
          end else if (i_ir == INSTR_RETURN) begin
            o_load_stack = 1'b1;
          end
        end else begin
          o_alu_d     = i_ir[7];
          o_d_wr      = 1'b1;
          o_status_wr = 1'b1;
          case (i_ir[11:8])
            BOP_CLR:   o_alu_op = ALU_ZERO;
            BOP_SUBWF: o_alu_op = ALU_SUB;
            BOP_DECF:  o_alu_op = ALU_DEC;
            BOP_IORWF: o_alu_op = ALU_OR;
            BOP_ANDWF: o_alu_op = ALU_AND;
            BOP_XORWF: o_alu_op = ALU_XOR;
            BOP_ADDWF: o_alu_op = ALU_ADD;
            BOP_MOVF:  o_alu_op = ALU_PASSLF;
            BOP_COMF:  o_alu_op = ALU_COM;
            BOP_INCF:  o_alu_op = ALU_INC;
            BOP_DECFSZ: begin
              o_alu_op    = ALU_DEC;
              o_status_wr = 1'b0;
              o_skip_zero = 1'b1;
            end
            BOP_RRF:   o_alu_op = ALU_RRF;
            BOP_RLF:   o_alu_op = ALU_RLF;
            BOP_SWAPF: begin
              o_alu_op    = ALU_SWAPF;
              o_status_wr = 1'b0;
            end
            BOP_INCFSZ: begin
              o_alu_op    = ALU_INC;
              o_status_wr = 1'b0;
              o_skip_zero = 1'b1;
            end
            default: o_alu_op = ALU_ADD;
          endcase
        end
      end
      GRP_BIT: begin
        o_alu_d = 1'b1;
        case (i_ir[11:10])
          BIT_BCF: begin
            o_alu_op = ALU_BC;
            o_d_wr   = 1'b1;
          end
          BIT_BSF: begin
            o_alu_op = ALU_BS;
            o_d_wr   = 1'b1;
          end
          BIT_BTFSC: begin
            o_alu_op   = ALU_BC;
            o_skip_bit = 1'b1;
          end
          default: begin
            o_alu_op   = ALU_BS;
            o_skip_bit = 1'b1;
          end
        endcase
      end
      GRP_CTRL: begin
        // ir[11]=1 goto, ir[11]=0 call
        o_load_lit   = 1'b1;
        o_stack_push = ~i_ir[11];
      end
      default: begin
        o_lit_sel   = 1'b1;
        o_d_wr      = 1'b1;
        o_status_wr = 1'b1;
        casez (i_ir[11:8])
          4'b00??: begin
            o_alu_op    = ALU_PASSLF;
            o_status_wr = 1'b0;
          end
          4'b01??: begin
            o_alu_op     = ALU_PASSLF;
            o_status_wr  = 1'b0;
            o_load_stack = 1'b1;
          end
          4'b1000: o_alu_op = ALU_OR;
          4'b1001: o_alu_op = ALU_AND;
          4'b1010: o_alu_op = ALU_XOR;
          4'b110?: o_alu_op = ALU_SUB;
          4'b111?: o_alu_op = ALU_ADD;
          default: begin
            o_lit_sel   = 1'b0;
            o_d_wr      = 1'b0;
            o_status_wr = 1'b0;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - Q1..Q4 cycle sequencer, instruction register and flush control
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int PC_WIDTH = 11
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [13:0]         instr,
  input  logic                alu_bit_test_res,
  input  logic                alu_zero_in,
  output logic [1:0]          q_phase,
  output logic [3:0]          alu_op,
  output logic                alu_d,
  output logic                alu_d_wr_en,
  output logic                alu_status_wr_en,
  output logic [2:0]          alu_b_in,
  output logic                lit_sel,
  output logic [7:0]          lit,
  output logic [6:0]          f_addr,
  output logic                ir_load,
  output logic                pc_inc,
  output logic                pc_load_lit,
  output logic                pc_load_stack,
  output logic                stack_push,
  output logic [PC_WIDTH-1:0] pc_target,
  output logic                flush
);

  q_phase_e    r_q;
  q_phase_e    w_q_next;
  logic [13:0] r_ir;
  logic [13:0] w_ir_next;
  logic        r_flush;
  logic        w_flush_next;
  logic        w_q4;
  logic        w_exec;

  logic        w_dec_d_wr;
  logic        w_dec_status_wr;
  logic        w_dec_push;
  logic        w_dec_load_lit;
  logic        w_dec_load_stack;
  logic        w_dec_skip_bit;
  logic        w_dec_skip_zero;

  instr_decode u_decode (
    .i_ir         (r_ir),
    .o_alu_op     (alu_op),
    .o_alu_d      (alu_d),
    .o_d_wr       (w_dec_d_wr),
    .o_status_wr  (w_dec_status_wr),
    .o_lit_sel    (lit_sel),
    .o_stack_push (w_dec_push),
    .o_load_lit   (w_dec_load_lit),
    .o_load_stack (w_dec_load_stack),
    .o_skip_bit   (w_dec_skip_bit),
    .o_skip_zero  (w_dec_skip_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q     <= Q1;
      r_ir    <= INSTR_NOP;
      r_flush <= 1'b1;
    end else begin
      r_q     <= w_q_next;
      r_ir    <= w_ir_next;
      r_flush <= w_flush_next;
    end
  end

  // The flush decision is made only by an unflushed slot on its Q4->Q1 edge.
  always_comb begin
    w_q_next     = r_q;
    w_ir_next    = r_ir;
    w_flush_next = r_flush;
    case (r_q)
      Q1: w_q_next = Q2;
      Q2: w_q_next = Q3;
      Q3: w_q_next = Q4;
      default: begin
        w_q_next     = Q1;
        w_ir_next    = instr;
        w_flush_next = !r_flush &&
                       (w_dec_load_lit || w_dec_load_stack ||
                        (w_dec_skip_bit && alu_bit_test_res) ||
                        (w_dec_skip_zero && alu_zero_in));
      end
    endcase
  end

  always_comb begin
    w_q4             = (r_q == Q4);
    w_exec           = w_q4 && !r_flush;
    ir_load          = w_q4;
    pc_inc           = w_q4;
    alu_d_wr_en      = w_exec && w_dec_d_wr;
    alu_status_wr_en = w_exec && w_dec_status_wr;
    stack_push       = w_exec && w_dec_push;
    pc_load_lit      = w_exec && w_dec_load_lit;
    pc_load_stack    = w_exec && w_dec_load_stack;
  end

  assign q_phase   = r_q;
  assign flush     = r_flush;
  assign alu_b_in  = r_ir[9:7];
  assign lit       = r_ir[7:0];
  assign f_addr    = r_ir[6:0];
  assign pc_target = PC_WIDTH'(r_ir[10:0]);

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed bench with a mnemonic-level model of instr_sequencer
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  localparam int PC_WIDTH = 11;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [13:0]         instr = '0;
  logic                alu_bit_test_res = 1'b0;
  logic                alu_zero_in = 1'b0;
  logic [1:0]          q_phase;
  logic [3:0]          alu_op;
  logic                alu_d;
  logic                alu_d_wr_en;
  logic                alu_status_wr_en;
  logic [2:0]          alu_b_in;
  logic                lit_sel;
  logic [7:0]          lit;
  logic [6:0]          f_addr;
  logic                ir_load;
  logic                pc_inc;
  logic                pc_load_lit;
  logic                pc_load_stack;
  logic                stack_push;
  logic [PC_WIDTH-1:0] pc_target;
  logic                flush;

  always #5 clk = ~clk;

  instr_sequencer #(.PC_WIDTH(PC_WIDTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .instr            (instr),
    .alu_bit_test_res (alu_bit_test_res),
    .alu_zero_in      (alu_zero_in),
    .q_phase          (q_phase),
    .alu_op           (alu_op),
    .alu_d            (alu_d),
    .alu_d_wr_en      (alu_d_wr_en),
    .alu_status_wr_en (alu_status_wr_en),
    .alu_b_in         (alu_b_in),
    .lit_sel          (lit_sel),
    .lit              (lit),
    .f_addr           (f_addr),
    .ir_load          (ir_load),
    .pc_inc           (pc_inc),
    .pc_load_lit      (pc_load_lit),
    .pc_load_stack    (pc_load_stack),
    .stack_push       (stack_push),
    .pc_target        (pc_target),
    .flush            (flush)
  );

  typedef enum {
    M_NOP, M_RETURN, M_MOVWF, M_CLR, M_SUBWF, M_DECF, M_IORWF, M_ANDWF, M_XORWF,
    M_ADDWF, M_MOVF, M_COMF, M_INCF, M_DECFSZ, M_RRF, M_RLF, M_SWAPF, M_INCFSZ,
    M_BCF, M_BSF, M_BTFSC, M_BTFSS, M_CALL, M_GOTO,
    M_MOVLW, M_RETLW, M_IORLW, M_ANDLW, M_XORLW, M_SUBLW, M_ADDLW
  } mnem_e;

  typedef struct packed {
    logic [3:0] op;
    logic       d;
    logic       wr;
    logic       st;
    logic       lsel;
    logic       push;
    logic       ldlit;
    logic       ldstk;
    logic       bskip;
    logic       zskip;
  } exp_t;

  int n_vec = 0;
  int n_err = 0;
  bit done  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic mnem_e byte_mnem(input int sub);
    case (sub)
      1: return M_CLR;    2: return M_SUBWF;   3: return M_DECF;   4: return M_IORWF;
      5: return M_ANDWF;  6: return M_XORWF;   7: return M_ADDWF;  8: return M_MOVF;
      9: return M_COMF;   10: return M_INCF;   11: return M_DECFSZ; 12: return M_RRF;
      13: return M_RLF;   14: return M_SWAPF;  15: return M_INCFSZ;
      default: return M_NOP;
    endcase
  endfunction

  function automatic mnem_e classify(input logic [13:0] w);
    int v, grp, sub;
    v   = int'(w);
    grp = v / 4096;
    sub = (v / 256) % 16;
    if (v == 8) return M_RETURN;
    case (grp)
      0: begin
        if (sub != 0) return byte_mnem(sub);
        return ((v / 128) % 2 == 1) ? M_MOVWF : M_NOP;
      end
      1: begin
        case ((v / 1024) % 4)
          0: return M_BCF;
          1: return M_BSF;
          2: return M_BTFSC;
          default: return M_BTFSS;
        endcase
      end
      2: return ((v / 2048) % 2 == 1) ? M_GOTO : M_CALL;
      default: begin
        if (sub < 4) return M_MOVLW;
        if (sub < 8) return M_RETLW;
        if (sub == 8) return M_IORLW;
        if (sub == 9) return M_ANDLW;
        if (sub == 10) return M_XORLW;
        if (sub == 11) return M_NOP;
        return (sub < 14) ? M_SUBLW : M_ADDLW;
      end
    endcase
  endfunction

  function automatic exp_t exp_of(input logic [13:0] w);
    exp_t  e;
    mnem_e m;
    m    = classify(w);
    e    = '0;
    case (m)
      M_CLR:                        e.op = ALU_ZERO;
      M_SUBWF, M_SUBLW:             e.op = ALU_SUB;
      M_DECF, M_DECFSZ:             e.op = ALU_DEC;
      M_IORWF, M_IORLW:             e.op = ALU_OR;
      M_ANDWF, M_ANDLW:             e.op = ALU_AND;
      M_XORWF, M_XORLW:             e.op = ALU_XOR;
      M_MOVF, M_MOVLW, M_RETLW:     e.op = ALU_PASSLF;
      M_COMF:                       e.op = ALU_COM;
      M_INCF, M_INCFSZ:             e.op = ALU_INC;
      M_RRF:                        e.op = ALU_RRF;
      M_RLF:                        e.op = ALU_RLF;
      M_SWAPF:                      e.op = ALU_SWAPF;
      M_MOVWF:                      e.op = ALU_PASSW;
      M_BCF, M_BTFSC:               e.op = ALU_BC;
      M_BSF, M_BTFSS:               e.op = ALU_BS;
      default:                      e.op = ALU_ADD;
    endcase
    if (m inside {M_CLR, M_SUBWF, M_DECF, M_IORWF, M_ANDWF, M_XORWF, M_ADDWF, M_MOVF,
                  M_COMF, M_INCF, M_DECFSZ, M_RRF, M_RLF, M_SWAPF, M_INCFSZ}) begin
      e.d     = w[7];
      e.wr    = 1'b1;
      e.st    = !(m inside {M_DECFSZ, M_INCFSZ, M_SWAPF});
      e.zskip = (m inside {M_DECFSZ, M_INCFSZ});
    end
    if (m == M_MOVWF) begin
      e.d  = 1'b1;
      e.wr = 1'b1;
    end
    if (m inside {M_BCF, M_BSF, M_BTFSC, M_BTFSS}) begin
      e.d     = 1'b1;
      e.wr    = (m inside {M_BCF, M_BSF});
      e.bskip = (m inside {M_BTFSC, M_BTFSS});
    end
    if (m inside {M_MOVLW, M_RETLW, M_IORLW, M_ANDLW, M_XORLW, M_SUBLW, M_ADDLW}) begin
      e.lsel = 1'b1;
      e.wr   = 1'b1;
      e.st   = !(m inside {M_MOVLW, M_RETLW});
    end
    e.ldstk = (m inside {M_RETURN, M_RETLW});
    e.ldlit = (m inside {M_GOTO, M_CALL});
    e.push  = (m == M_CALL);
    return e;
  endfunction

  // Model state: which cycle of the slot we are in, the slot's word, and whether it is squashed.
  int          m_phase = 0;
  logic [13:0] m_ir = '0;
  bit          m_flushed = 1'b1;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    exp_t e;
    if (!rst_n) begin
      m_phase   = 0;
      m_ir      = '0;
      m_flushed = 1'b1;
      m_valid   = 1'b1;
    end else if (m_valid) begin
      if (m_phase == 3) begin
        e = exp_of(m_ir);
        m_flushed = !m_flushed && (e.ldlit || e.ldstk ||
                                   (e.bskip && alu_bit_test_res == 1'b1) ||
                                   (e.zskip && alu_zero_in == 1'b1));
        m_ir    = instr;
        m_phase = 0;
      end else begin
        m_phase = m_phase + 1;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    bit   q4;
    bit   ex;
    if (m_valid && !done) begin
      e  = exp_of(m_ir);
      q4 = (m_phase == 3);
      ex = q4 && !m_flushed;
      chk("q_phase",       32'(q_phase),          32'(m_phase));
      chk("flush",         32'(flush),            32'(m_flushed));
      chk("alu_op",        32'(alu_op),           32'(e.op));
      chk("alu_d",         32'(alu_d),            32'(e.d));
      chk("lit_sel",       32'(lit_sel),          32'(e.lsel));
      chk("lit",           32'(lit),              32'(int'(m_ir) % 256));
      chk("f_addr",        32'(f_addr),           32'(int'(m_ir) % 128));
      chk("alu_b_in",      32'(alu_b_in),         32'((int'(m_ir) / 128) % 8));
      chk("pc_target",     32'(pc_target),        32'(int'(m_ir) % 2048));
      chk("ir_load",       32'(ir_load),          32'(q4));
      chk("pc_inc",        32'(pc_inc),           32'(q4));
      chk("alu_d_wr_en",   32'(alu_d_wr_en),      32'(ex && e.wr));
      chk("status_wr_en",  32'(alu_status_wr_en), 32'(ex && e.st));
      chk("stack_push",    32'(stack_push),       32'(ex && e.push));
      chk("pc_load_lit",   32'(pc_load_lit),      32'(ex && e.ldlit));
      chk("pc_load_stack", 32'(pc_load_stack),    32'(ex && e.ldstk));
    end
  end

  task automatic to_q4();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_phase != 3 && n < 8);
    chk("q4_sync", 32'(m_phase), 32'd3);
  endtask

  // Present the next word plus the skip inputs for the slot now in Q4, then run to the next Q4.
  task automatic slot(input logic [13:0] nxt, input logic bt, input logic z);
    instr            = nxt;
    alu_bit_test_res = bt;
    alu_zero_in      = z;
    to_q4();
    alu_bit_test_res = 1'b0;
    alu_zero_in      = 1'b0;
  endtask

  logic [13:0] mix [31] = '{
    14'h0000, 14'h0009, 14'h0063, 14'h0064, 14'h00A5, 14'h0103, 14'h0185, 14'h0245,
    14'h03C6, 14'h0447, 14'h0548, 14'h06C9, 14'h0850, 14'h0951, 14'h0A52, 14'h0F53,
    14'h0C54, 14'h0D55, 14'h0E56, 14'h1056, 14'h1580, 14'h1812, 14'h1F7F, 14'h3811,
    14'h3922, 14'h3A33, 14'h3B44, 14'h3C55, 14'h3E66, 14'h2FFF, 14'h27FF
  };

  initial begin
    exp_t pin;
    pin = exp_of(14'h0BA1);
    chk("model decfsz wr", 32'(pin.wr), 32'd1);
    chk("model decfsz st", 32'(pin.st), 32'd0);
    chk("model decfsz zskip", 32'(pin.zskip), 32'd1);
    pin = exp_of(14'h305A);
    chk("model movlw op", 32'(pin.op), 32'(ALU_PASSLF));
    chk("model movlw lsel", 32'(pin.lsel), 32'd1);

    repeat (2) @(negedge clk);
    chk("rst q_phase", 32'(q_phase), 32'd0);
    chk("rst flush", 32'(flush), 32'd1);
    chk("rst d_wr", 32'(alu_d_wr_en), 32'd0);
    chk("rst ir_load", 32'(ir_load), 32'd0);
    chk("rst pc_load_lit", 32'(pc_load_lit), 32'd0);
    rst_n = 1'b1;
    to_q4();

    slot(14'h07A0, 1'b0, 1'b0);
    chk("addwf op", 32'(alu_op), 32'(ALU_ADD));
    chk("addwf d", 32'(alu_d), 32'd1);
    chk("addwf f_addr", 32'(f_addr), 32'h20);
    chk("addwf lit_sel", 32'(lit_sel), 32'd0);
    chk("addwf d_wr", 32'(alu_d_wr_en), 32'd1);
    chk("addwf st_wr", 32'(alu_status_wr_en), 32'd1);

    slot(14'h2923, 1'b0, 1'b0);
    chk("goto flush", 32'(flush), 32'd0);
    chk("goto load_lit", 32'(pc_load_lit), 32'd1);
    chk("goto target", 32'(pc_target), 32'h123);
    chk("goto pc_inc", 32'(pc_inc), 32'd1);

    slot(14'h07A0, 1'b0, 1'b0);
    chk("post-goto flush", 32'(flush), 32'd1);
    chk("post-goto d_wr", 32'(alu_d_wr_en), 32'd0);
    chk("post-goto st_wr", 32'(alu_status_wr_en), 32'd0);
    chk("post-goto ir_load", 32'(ir_load), 32'd1);

    slot(14'h1D03, 1'b0, 1'b0);
    chk("btfss flush", 32'(flush), 32'd0);
    chk("btfss op", 32'(alu_op), 32'(ALU_BS));
    chk("btfss b_in", 32'(alu_b_in), 32'd2);
    chk("btfss d_wr", 32'(alu_d_wr_en), 32'd0);
    slot(14'h07A0, 1'b1, 1'b0);
    chk("btfss taken flush", 32'(flush), 32'd1);
    slot(14'h1D03, 1'b1, 1'b0);
    chk("flushed btfss flush", 32'(flush), 32'd0);
    slot(14'h07A0, 1'b0, 1'b0);
    chk("btfss not taken flush", 32'(flush), 32'd0);
    chk("btfss not taken d_wr", 32'(alu_d_wr_en), 32'd1);

    slot(14'h0BA1, 1'b0, 1'b0);
    chk("decfsz d_wr", 32'(alu_d_wr_en), 32'd1);
    chk("decfsz st_wr", 32'(alu_status_wr_en), 32'd0);
    slot(14'h07A0, 1'b0, 1'b1);
    chk("decfsz taken flush", 32'(flush), 32'd1);
    slot(14'h0BA1, 1'b0, 1'b0);
    slot(14'h07A0, 1'b0, 1'b0);
    chk("decfsz not taken flush", 32'(flush), 32'd0);

    slot(14'h305A, 1'b0, 1'b0);
    chk("movlw lit_sel", 32'(lit_sel), 32'd1);
    chk("movlw lit", 32'(lit), 32'h5A);
    chk("movlw op", 32'(alu_op), 32'(ALU_PASSLF));
    chk("movlw d", 32'(alu_d), 32'd0);
    chk("movlw d_wr", 32'(alu_d_wr_en), 32'd1);
    chk("movlw st_wr", 32'(alu_status_wr_en), 32'd0);
    slot(14'h2010, 1'b0, 1'b0);
    chk("call push", 32'(stack_push), 32'd1);
    chk("call load_lit", 32'(pc_load_lit), 32'd1);
    chk("call target", 32'(pc_target), 32'h010);

    slot(14'h0008, 1'b0, 1'b0);
    chk("flushed return load_stack", 32'(pc_load_stack), 32'd0);
    slot(14'h0008, 1'b0, 1'b0);
    chk("return load_stack", 32'(pc_load_stack), 32'd1);
    chk("return d_wr", 32'(alu_d_wr_en), 32'd0);
    slot(14'h3455, 1'b0, 1'b0);
    slot(14'h3455, 1'b0, 1'b0);
    chk("retlw load_stack", 32'(pc_load_stack), 32'd1);
    chk("retlw d_wr", 32'(alu_d_wr_en), 32'd1);

    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 31; i++) begin
        slot(mix[i], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end

    slot(14'h07A0, 1'b0, 1'b0);
    instr = 14'h07A0;
    repeat (3) @(negedge clk);
    chk("pre-reset q_phase", 32'(q_phase), 32'd2);
    chk("pre-reset flush", 32'(flush), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid-reset q_phase", 32'(q_phase), 32'd0);
    chk("mid-reset flush", 32'(flush), 32'd1);
    to_q4();
    chk("mid-reset d_wr", 32'(alu_d_wr_en), 32'd0);
    chk("mid-reset st_wr", 32'(alu_status_wr_en), 32'd0);
    slot(14'h07A0, 1'b0, 1'b0);
    chk("post-reset addwf d_wr", 32'(alu_d_wr_en), 32'd1);

    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

endmodule
